la_mac_bridge: RTL and testbench

- User-project stage that sits between the management SoC's logic-analyzer (LA) bus and the user GPIO pads.
- Executes firmware-issued commands against a multiply-accumulate datapath: clear, MAC, check-against-expected, NOP.
- Reports results on la_data_out and drives a 16-bit status word on io_out[31:16]. The chip-level bench monitors that word: 0xAB60 means started, 0xAB61 means check passed.

---
 rtl/la_mac_bridge_pkg.sv | 30 +++
 rtl/la_mac_bridge_if.sv | 27 ++
 rtl/la_mac_bridge_serial_mul.sv | 56 +++++
 rtl/la_mac_bridge.sv | 141 ++++++++++++++
 tb/tb_la_mac_bridge.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_mac_bridge_pkg.sv
// Shared definitions for the LA-driven multiply-accumulate bridge:
// opcodes, FSM encoding and LA bus field positions.
`timescale 1ns / 1ps
package la_mac_pkg;

    localparam int unsigned LA_W = 128;
    localparam int unsigned IO_W = 38;

    localparam logic [1:0] OP_CLR   = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_CHECK = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ACC  = 2'b10,
        ACK  = 2'b11
    } state_e;

    localparam int unsigned STROBE_BIT = 16;
    localparam int unsigned OPC_LSB    = 17;
    localparam int unsigned EXP_LSB    = 32;
    localparam int unsigned ACK_BIT    = 32;
    localparam int unsigned BUSY_BIT   = 33;
    localparam int unsigned OVR_BIT    = 34;
    localparam int unsigned SAT_BIT    = 35;
    localparam int unsigned MATCH_BIT  = 36;

endpackage

// File: rtl/la_mac_bridge_if.sv
// LA bus plus user GPIO pad signals between the management SoC side and the bridge.
`timescale 1ns / 1ps
interface la_mac_bridge_if;

    logic [la_mac_pkg::LA_W-1:0] la_data_in;
    logic [la_mac_pkg::LA_W-1:0] la_oenb;
    logic [la_mac_pkg::LA_W-1:0] la_data_out;
    logic [la_mac_pkg::IO_W-1:0] io_out;
    logic [la_mac_pkg::IO_W-1:0] io_oeb;

    modport master (
        output la_data_in,
        output la_oenb,
        input  la_data_out,
        input  io_out,
        input  io_oeb
    );

    modport slave (
        input  la_data_in,
        input  la_oenb,
        output la_data_out,
        output io_out,
        output io_oeb
    );

endinterface

// File: rtl/la_mac_bridge_serial_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle over DATA_W cycles.
// Bit 0 is consumed on the start cycle; product holds until the next start.
`timescale 1ns / 1ps
module serial_mul #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [PW-1:0]     mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product  <= a[0] ? PW'(b) : '0;
                mcand_q  <= PW'(b) << 1;
                mplier_q <= a >> 1;
                cnt_q    <= CNT_W'(DATA_W - 1);
                run_q    <= (DATA_W > 1);
                done     <= (DATA_W == 1);
            end else if (run_q) begin
                if (mplier_q[0]) begin
                    product <= product + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/la_mac_bridge.sv
// Executes toggle-strobed LA commands (clear, MAC, check, nop) on a saturating
// accumulator and reports results on la_data_out and a status word on io_out[31:16].
`timescale 1ns / 1ps
module la_mac_bridge
    import la_mac_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 32,
    parameter logic [11:0] STATUS_TAG = 12'hAB6
) (
    input logic          wb_clk_i,
    input logic          wb_rst_i,
    la_mac_bridge_if.slave la
);

    localparam int unsigned SUM_W = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 1;

    state_e              state_q;
    logic [1:0]          op_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    exp_q;
    logic                strobe_q;
    logic                arm_q;
    logic                ack_q;
    logic                busy_q;
    logic                ovr_q;
    logic                sat_q;
    logic                match_q;

    logic                strobe_edge;
    logic                take;
    logic [1:0]          opc_in;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] product;
    logic [SUM_W-1:0]    sum;
    logic                sat_hit;
    logic                unused_la;

    assign unused_la   = ^{la.la_data_in, la.la_oenb};
    assign strobe_edge = (la.la_data_in[STROBE_BIT] != strobe_q) & ~la.la_oenb[STROBE_BIT] & arm_q;
    assign take        = strobe_edge & (state_q == IDLE);
    assign opc_in      = la.la_data_in[OPC_LSB +: 2];
    assign mul_start   = take & (opc_in == OP_MAC);

    serial_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .start   (mul_start),
        .a       (la.la_data_in[DATA_W-1:0]),
        .b       (la.la_data_in[8 +: DATA_W]),
        .done    (mul_done),
        .product (product)
    );

    // Any bit above ACC_W means the true sum no longer fits: clamp to all-ones.
    always_comb begin
        sum     = SUM_W'(acc_q) + SUM_W'(product);
        sat_hit = |sum[SUM_W-1:ACC_W];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            acc_q    <= '0;
            exp_q    <= '0;
            strobe_q <= 1'b0;
            arm_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sat_q    <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            strobe_q <= la.la_data_in[STROBE_BIT];
            arm_q    <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        op_q    <= opc_in;
                        exp_q   <= la.la_data_in[EXP_LSB +: ACC_W];
                        busy_q  <= 1'b1;
                        state_q <= (opc_in == OP_MAC) ? MUL : ACK;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (sat_hit) begin
                        acc_q <= '1;
                        sat_q <= 1'b1;
                    end else begin
                        acc_q <= sum[ACC_W-1:0];
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    case (op_q)
                        OP_CLR: begin
                            acc_q   <= '0;
                            match_q <= 1'b0;
                            ovr_q   <= 1'b0;
                            sat_q   <= 1'b0;
                        end
                        OP_CHECK: match_q <= (acc_q == exp_q);
                        default: ;
                    endcase
                    ack_q   <= ~ack_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Placed last so an edge landing on the ACK of a CLR still records the drop.
            if (strobe_edge && (state_q != IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        la.la_data_out              = '0;
        la.la_data_out[ACC_W-1:0]   = acc_q;
        la.la_data_out[ACK_BIT]     = ack_q;
        la.la_data_out[BUSY_BIT]    = busy_q;
        la.la_data_out[OVR_BIT]     = ovr_q;
        la.la_data_out[SAT_BIT]     = sat_q;
        la.la_data_out[MATCH_BIT]   = match_q;
        la.io_out                   = '0;
        la.io_out[31:16]            = {STATUS_TAG, 3'b000, match_q};
        la.io_oeb                   = '1;
        la.io_oeb[31:16]            = '0;
    end

endmodule

// File: tb/tb_la_mac_bridge.sv
// Directed self-checking bench for la_mac_bridge: default instance plus an ACC_W=20
// instance for saturation.
`timescale 1ns / 1ps
module tb_la_mac_bridge;
    import la_mac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] din  [2];
    logic [127:0] oenb [2];
    logic [127:0] dout [2];
    logic [37:0]  iout [2];
    logic [37:0]  ioeb [2];

    la_mac_bridge_if bus0 ();
    la_mac_bridge_if bus1 ();

    assign bus0.la_data_in = din[0];
    assign bus0.la_oenb    = oenb[0];
    assign bus1.la_data_in = din[1];
    assign bus1.la_oenb    = oenb[1];
    assign dout[0] = bus0.la_data_out;
    assign dout[1] = bus1.la_data_out;
    assign iout[0] = bus0.io_out;
    assign iout[1] = bus1.io_out;
    assign ioeb[0] = bus0.io_oeb;
    assign ioeb[1] = bus1.io_oeb;

    la_mac_bridge dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .la       (bus0)
    );

    la_mac_bridge #(
        .ACC_W (20)
    ) dut20 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .la       (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    bit bok;

    // Issue one command and measure posedges from capture until ack toggles.
    task automatic do_cmd(input int sel, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [31:0] expv,
                          output int lat_o, output bit busy_ok);
        logic ack0;
        @(negedge clk);
        din[sel][7:0]   = a;
        din[sel][15:8]  = b;
        din[sel][18:17] = op;
        din[sel][63:32] = expv;
        din[sel][16]    = ~din[sel][16];
        ack0    = dout[sel][32];
        lat_o   = -1;
        busy_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (dout[sel][32] !== ack0) begin
                lat_o = c;
                if (dout[sel][33] !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (dout[sel][33] !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            din[s]      = '0;
            din[s][16]  = 1'b1;
            oenb[s]     = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dout[0] !== 128'd0) begin
            $display("FAIL reset_hold la_data_out got=%h want=0", dout[0]);
            n_fail++;
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (dout[0] !== 128'd0) begin
            $display("FAIL reset_release la_data_out got=%h want=0", dout[0]);
            n_fail++;
        end
        n_checks++;
        if (dout[1] !== 128'd0) begin
            $display("FAIL reset_release20 la_data_out got=%h want=0", dout[1]);
            n_fail++;
        end
        n_checks++;
        if (iout[0] !== 38'h00AB600000) begin
            $display("FAIL reset_io_out got=%h want=00ab600000", iout[0]);
            n_fail++;
        end
        n_checks++;
        if (ioeb[0] !== 38'h3F0000FFFF) begin
            $display("FAIL reset_io_oeb got=%h want=3f0000ffff", ioeb[0]);
            n_fail++;
        end
    endtask

    task automatic test_mac;
        logic [127:0] want;
        do_cmd(0, OP_CLR, 8'd0, 8'd0, 32'd0, lat, bok);
        n_checks++;
        if (lat !== 1) begin
            $display("FAIL clr_latency got=%0d want=1", lat);
            n_fail++;
        end
        do_cmd(0, OP_MAC, 8'd3, 8'd5, 32'd0, lat, bok);
        n_checks++;
        if (lat !== 10 || bok !== 1'b1) begin
            $display("FAIL mac1_timing got lat=%0d busy_ok=%0d want 10/1", lat, bok);
            n_fail++;
        end
        n_checks++;
        if (dout[0][31:0] !== 32'd15) begin
            $display("FAIL mac1_acc got=%0d want=15", dout[0][31:0]);
            n_fail++;
        end
        do_cmd(0, OP_MAC, 8'd255, 8'd255, 32'd0, lat, bok);
        n_checks++;
        if (lat !== 10 || bok !== 1'b1) begin
            $display("FAIL mac2_timing got lat=%0d busy_ok=%0d want 10/1", lat, bok);
            n_fail++;
        end
        want = {91'd0, 5'b00001, 32'd65040};
        n_checks++;
        if (dout[0] !== want) begin
            $display("FAIL mac2_word got=%h want=%h", dout[0], want);
            n_fail++;
        end
    endtask

    task automatic test_check;
        do_cmd(0, OP_CHECK, 8'd0, 8'd0, 32'd65040, lat, bok);
        n_checks++;
        if (lat !== 1) begin
            $display("FAIL check_latency got=%0d want=1", lat);
            n_fail++;
        end
        n_checks++;
        if (iout[0][31:16] !== 16'hAB61 || dout[0][36] !== 1'b1) begin
            $display("FAIL check_pass got status=%h match=%b want ab61/1", iout[0][31:16],
                     dout[0][36]);
            n_fail++;
        end
        do_cmd(0, OP_CHECK, 8'd0, 8'd0, 32'd0, lat, bok);
        n_checks++;
        if (iout[0][31:16] !== 16'hAB60 || dout[0][36] !== 1'b0) begin
            $display("FAIL check_miss got status=%h match=%b want ab60/0", iout[0][31:16],
                     dout[0][36]);
            n_fail++;
        end
        n_checks++;
        if (dout[0][31:0] !== 32'd65040) begin
            $display("FAIL check_acc_kept got=%0d want=65040", dout[0][31:0]);
            n_fail++;
        end
    endtask

    task automatic test_saturate;
        do_cmd(1, OP_CLR, 8'd0, 8'd0, 32'd0, lat, bok);
        for (int i = 0; i < 16; i++) do_cmd(1, OP_MAC, 8'd255, 8'd255, 32'd0, lat, bok);
        n_checks++;
        if (dout[1][19:0] !== 20'hFE010 || dout[1][35] !== 1'b0) begin
            $display("FAIL sat_pre got acc=%h sat=%b want fe010/0", dout[1][19:0], dout[1][35]);
            n_fail++;
        end
        do_cmd(1, OP_MAC, 8'd255, 8'd255, 32'd0, lat, bok);
        n_checks++;
        if (dout[1][31:0] !== 32'h000FFFFF || dout[1][35] !== 1'b1) begin
            $display("FAIL sat_hit got acc=%h sat=%b want 000fffff/1", dout[1][31:0],
                     dout[1][35]);
            n_fail++;
        end
        do_cmd(1, OP_MAC, 8'd255, 8'd255, 32'd0, lat, bok);
        n_checks++;
        if (dout[1][19:0] !== 20'hFFFFF || dout[1][35] !== 1'b1 || lat !== 10) begin
            $display("FAIL sat_hold got acc=%h sat=%b lat=%0d want fffff/1/10", dout[1][19:0],
                     dout[1][35], lat);
            n_fail++;
        end
        do_cmd(1, OP_CLR, 8'd0, 8'd0, 32'd0, lat, bok);
        n_checks++;
        if (dout[1][19:0] !== 20'h0 || dout[1][35] !== 1'b0) begin
            $display("FAIL sat_clr got acc=%h sat=%b want 0/0", dout[1][19:0], dout[1][35]);
            n_fail++;
        end
    endtask

    task automatic test_overrun;
        logic prev;
        int   toggles;
        int   first;
        do_cmd(0, OP_CLR, 8'd0, 8'd0, 32'd0, lat, bok);
        @(negedge clk);
        din[0][7:0]   = 8'd2;
        din[0][15:8]  = 8'd2;
        din[0][18:17] = OP_MAC;
        din[0][16]    = ~din[0][16];
        prev    = dout[0][32];
        toggles = 0;
        first   = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (dout[0][32] !== prev) begin
                toggles++;
                if (first < 0) first = c;
                prev = dout[0][32];
            end
            if (c == 2) begin
                @(negedge clk);
                din[0][16] = ~din[0][16];
            end
        end
        n_checks++;
        if (toggles !== 1 || first !== 10) begin
            $display("FAIL ovr_ack got toggles=%0d at=%0d want 1 at 10", toggles, first);
            n_fail++;
        end
        n_checks++;
        if (dout[0][31:0] !== 32'd4 || dout[0][34] !== 1'b1) begin
            $display("FAIL ovr_state got acc=%0d ovr=%b want 4/1", dout[0][31:0], dout[0][34]);
            n_fail++;
        end
        @(negedge clk);
        oenb[0][16] = 1'b1;
        din[0][16]  = ~din[0][16];
        prev    = dout[0][32];
        toggles = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (dout[0][32] !== prev || dout[0][33] !== 1'b0) toggles++;
            if (c == 2) begin
                @(negedge clk);
                din[0][16] = ~din[0][16];
            end
        end
        n_checks++;
        if (toggles !== 0 || dout[0][31:0] !== 32'd4) begin
            $display("FAIL oenb_ignore got activity=%0d acc=%0d want 0/4", toggles,
                     dout[0][31:0]);
            n_fail++;
        end
        @(negedge clk);
        oenb[0][16] = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        din[0][7:0]   = 8'd5;
        din[0][15:8]  = 8'd6;
        din[0][18:17] = OP_MAC;
        din[0][16]    = ~din[0][16];
        repeat (5) @(negedge clk);
        n_checks++;
        if (dout[0][33] !== 1'b1) begin
            $display("FAIL mid_busy got=%b want=1", dout[0][33]);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dout[0] !== 128'd0 || iout[0] !== 38'h00AB600000) begin
            $display("FAIL mid_reset got out=%h io=%h want 0/00ab600000", dout[0], iout[0]);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_cmd(0, OP_MAC, 8'd7, 8'd9, 32'd0, lat, bok);
        n_checks++;
        if (lat !== 10 || dout[0][31:0] !== 32'd63 || dout[0][34] !== 1'b0) begin
            $display("FAIL post_reset_mac got lat=%0d acc=%0d ovr=%b want 10/63/0", lat,
                     dout[0][31:0], dout[0][34]);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_mac();
        test_check();
        test_saturate();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
